// File: rtl/radar_rx_pkg.sv
// Shared definitions for the radar receive timing chain: default widths
// used by the pulse generator, the range gate controller and the accumulator,
// plus the range gate sweep state encoding.
package radar_rx_pkg;

  localparam int DEF_CFG_W = 32;
  localparam int DEF_BIN_W = 16;
  localparam int DEF_OVR_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    GATE  = 2'd2
  } rx_state_e;

endpackage

// File: rtl/rising_edge_detect.sv
// Single-register rising edge detector with a qualifying enable.
// The rise output is combinational from din so the consumer sees the edge
// in the same cycle the level first goes high.
module rising_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic en,
  output logic rise
);

  logic din_q;
  logic din_d;

  // Next value of the delay register is simply the current input level
  always_comb begin
    din_d = din;
  end

  // Delay register, cleared so a level already high after reset reads as an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      din_q <= 1'b0;
    end else begin
      din_q <= din_d;
    end
  end

  assign rise = din & ~din_q & en;

endmodule

// File: rtl/range_gate_controller.sv
// Receive-side range gate controller. After each transmit pulse edge it
// waits a blanking interval, then opens the receive gate and walks through
// fixed-length range bins, strobing the end of each bin. Triggers that land
// while a sweep is still running are counted in a saturating overrun counter.
module range_gate_controller
  import radar_rx_pkg::*;
#(
  parameter int CFG_W = DEF_CFG_W,
  parameter int BIN_W = DEF_BIN_W,
  parameter int OVR_W = DEF_OVR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             tx_pulse,
  input  logic [CFG_W-1:0] blank_cycles,
  input  logic [CFG_W-1:0] bin_cycles,
  input  logic [BIN_W-1:0] num_bins,
  input  logic             overrun_clr,
  output logic             gate_open,
  output logic             bin_strobe,
  output logic [BIN_W-1:0] bin_index,
  output logic             sweep_start,
  output logic             sweep_done,
  output logic             busy,
  output logic [OVR_W-1:0] overrun_cnt
);

  logic trig;
  logic accept;
  logic blank_last;
  logic bin_last;
  logic sweep_last;

  rx_state_e        state_q, state_d;
  logic [CFG_W-1:0] blank_lim_q, blank_lim_d;
  logic [CFG_W-1:0] bin_lim_q, bin_lim_d;
  logic [BIN_W-1:0] nbins_q, nbins_d;
  logic [CFG_W-1:0] blank_cnt_q, blank_cnt_d;
  logic [CFG_W-1:0] bin_cnt_q, bin_cnt_d;
  logic [BIN_W-1:0] bin_idx_q, bin_idx_d;
  logic [OVR_W-1:0] overrun_cnt_q, overrun_cnt_d;
  logic             gate_open_q, gate_open_d;
  logic             bin_strobe_q, bin_strobe_d;
  logic [BIN_W-1:0] bin_index_q, bin_index_d;
  logic             sweep_start_q, sweep_start_d;
  logic             sweep_done_q, sweep_done_d;
  logic             busy_q, busy_d;

  rising_edge_detect u_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (tx_pulse),
    .en   (enable),
    .rise (trig)
  );

  // Sweep sequencing, overrun counting and next values of the registered outputs
  always_comb begin
    state_d       = state_q;
    blank_lim_d   = blank_lim_q;
    bin_lim_d     = bin_lim_q;
    nbins_d       = nbins_q;
    blank_cnt_d   = blank_cnt_q;
    bin_cnt_d     = bin_cnt_q;
    bin_idx_d     = bin_idx_q;
    overrun_cnt_d = overrun_cnt_q;
    sweep_done_d  = 1'b0;

    accept     = trig && (state_q == IDLE) && (num_bins != '0);
    blank_last = (blank_cnt_q == blank_lim_q - CFG_W'(1));
    bin_last   = (bin_cnt_q == bin_lim_q - CFG_W'(1));
    sweep_last = (bin_idx_q == nbins_q - BIN_W'(1));

    if (!enable) begin
      state_d     = IDLE;
      blank_cnt_d = '0;
      bin_cnt_d   = '0;
      bin_idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            blank_lim_d = blank_cycles;
            bin_lim_d   = (bin_cycles == '0) ? CFG_W'(1) : bin_cycles;
            nbins_d     = num_bins;
            blank_cnt_d = '0;
            bin_cnt_d   = '0;
            bin_idx_d   = '0;
            state_d     = (blank_cycles == '0) ? GATE : BLANK;
          end
        end
        BLANK: begin
          if (blank_last) begin
            state_d   = GATE;
            bin_cnt_d = '0;
            bin_idx_d = '0;
          end else begin
            blank_cnt_d = blank_cnt_q + CFG_W'(1);
          end
        end
        GATE: begin
          if (bin_last) begin
            bin_cnt_d = '0;
            if (sweep_last) begin
              state_d      = IDLE;
              bin_idx_d    = '0;
              sweep_done_d = 1'b1;
            end else begin
              bin_idx_d = bin_idx_q + BIN_W'(1);
            end
          end else begin
            bin_cnt_d = bin_cnt_q + CFG_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (overrun_clr) begin
      overrun_cnt_d = '0;
    end else if (trig && (state_q != IDLE) && (overrun_cnt_q != '1)) begin
      overrun_cnt_d = overrun_cnt_q + OVR_W'(1);
    end

    sweep_start_d = accept;
    busy_d        = (state_d != IDLE);
    gate_open_d   = (state_d == GATE);
    bin_strobe_d  = (state_d == GATE) && (bin_cnt_d == bin_lim_d - CFG_W'(1));
    bin_index_d   = (state_d == GATE) ? bin_idx_d : '0;
  end

  // State, shadow configuration, counters and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      blank_lim_q   <= '0;
      bin_lim_q     <= '0;
      nbins_q       <= '0;
      blank_cnt_q   <= '0;
      bin_cnt_q     <= '0;
      bin_idx_q     <= '0;
      overrun_cnt_q <= '0;
      gate_open_q   <= 1'b0;
      bin_strobe_q  <= 1'b0;
      bin_index_q   <= '0;
      sweep_start_q <= 1'b0;
      sweep_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      blank_lim_q   <= blank_lim_d;
      bin_lim_q     <= bin_lim_d;
      nbins_q       <= nbins_d;
      blank_cnt_q   <= blank_cnt_d;
      bin_cnt_q     <= bin_cnt_d;
      bin_idx_q     <= bin_idx_d;
      overrun_cnt_q <= overrun_cnt_d;
      gate_open_q   <= gate_open_d;
      bin_strobe_q  <= bin_strobe_d;
      bin_index_q   <= bin_index_d;
      sweep_start_q <= sweep_start_d;
      sweep_done_q  <= sweep_done_d;
      busy_q        <= busy_d;
    end
  end

  assign gate_open   = gate_open_q;
  assign bin_strobe  = bin_strobe_q;
  assign bin_index   = bin_index_q;
  assign sweep_start = sweep_start_q;
  assign sweep_done  = sweep_done_q;
  assign busy        = busy_q;
  assign overrun_cnt = overrun_cnt_q;

endmodule

// File: tb/tb_range_gate_controller.sv
// Self-checking bench for range_gate_controller. A timeline model predicts
// every output from the sweep start cycle and the latched configuration
// using plain arithmetic; directed scenarios add fixed expectations.
// The overrun counter is built 8 bits wide so saturation is reachable quickly.
module tb_range_gate_controller;

  localparam int CFG_W = 32;
  localparam int BIN_W = 16;
  localparam int OVR_W = 8;
  localparam longint OVR_MAX = (longint'(1) << OVR_W) - 1;

  logic             clk;
  logic             rst;
  logic             enable;
  logic             tx_pulse;
  logic [CFG_W-1:0] blank_cycles;
  logic [CFG_W-1:0] bin_cycles;
  logic [BIN_W-1:0] num_bins;
  logic             overrun_clr;
  logic             gate_open;
  logic             bin_strobe;
  logic [BIN_W-1:0] bin_index;
  logic             sweep_start;
  logic             sweep_done;
  logic             busy;
  logic [OVR_W-1:0] overrun_cnt;

  int     checks;
  int     failures;
  longint cyc;

  bit     m_tx_d;
  bit     m_active;
  longint m_s;
  longint m_blank;
  longint m_bl;
  longint m_nb;
  longint m_ovr;

  logic [28:0] exp_vec;
  logic [28:0] obs;

  assign obs = {gate_open, bin_strobe, bin_index, sweep_start, sweep_done, busy, overrun_cnt};

  range_gate_controller #(
    .CFG_W (CFG_W),
    .BIN_W (BIN_W),
    .OVR_W (OVR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .tx_pulse     (tx_pulse),
    .blank_cycles (blank_cycles),
    .bin_cycles   (bin_cycles),
    .num_bins     (num_bins),
    .overrun_clr  (overrun_clr),
    .gate_open    (gate_open),
    .bin_strobe   (bin_strobe),
    .bin_index    (bin_index),
    .sweep_start  (sweep_start),
    .sweep_done   (sweep_done),
    .busy         (busy),
    .overrun_cnt  (overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock: apply the sweep rules to the inputs present at the
  // edge, then predict the outputs visible in the new cycle from its offset
  // inside the current sweep.
  task automatic tick();
    bit     trig;
    bit     busy_now;
    longint rel;
    longint total;
    bit     e_gate, e_strobe, e_start, e_done, e_busy;
    logic [15:0] e_idx;
    if (rst) begin
      m_active = 0;
      m_ovr    = 0;
      m_tx_d   = 0;
    end else begin
      trig     = tx_pulse && !m_tx_d && enable;
      busy_now = 0;
      if (m_active) begin
        rel      = cyc - m_s;
        total    = m_blank + m_nb * m_bl;
        busy_now = (rel < total);
      end
      if (overrun_clr) m_ovr = 0;
      else if (trig && busy_now && m_ovr < OVR_MAX) m_ovr++;
      if (!enable) begin
        m_active = 0;
      end else if (trig && !busy_now && num_bins != 0) begin
        m_active = 1;
        m_s      = cyc + 1;
        m_blank  = longint'(blank_cycles);
        m_bl     = (bin_cycles == 0) ? 1 : longint'(bin_cycles);
        m_nb     = longint'(num_bins);
      end
      m_tx_d = tx_pulse;
    end
    @(posedge clk);
    #1;
    cyc++;
    e_gate = 0; e_strobe = 0; e_start = 0; e_done = 0; e_busy = 0; e_idx = '0;
    if (m_active) begin
      rel     = cyc - m_s;
      total   = m_blank + m_nb * m_bl;
      e_start = (rel == 0);
      e_busy  = (rel < total);
      e_done  = (rel == total);
      e_gate  = (rel >= m_blank) && (rel < total);
      if (e_gate) begin
        e_idx    = 16'((rel - m_blank) / m_bl);
        e_strobe = (((rel - m_blank) % m_bl) == m_bl - 1);
      end
    end
    exp_vec = {e_gate, e_strobe, e_idx, e_start, e_done, e_busy, OVR_W'(m_ovr)};
  endtask

  task automatic set_cfg(input int bl, input int bn, input int nb);
    blank_cycles = CFG_W'(bl);
    bin_cycles   = CFG_W'(bn);
    num_bins     = BIN_W'(nb);
  endtask

  // Reset clears everything; a level already high right after reset is an edge
  task automatic test_reset();
    rst = 1; enable = 1; tx_pulse = 1; overrun_clr = 0;
    set_cfg(0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec) begin
        failures++;
        $display("[TB] FAIL reset_model cyc=%0d got=%h want=%h", cyc, obs, exp_vec);
      end
    end
    checks++;
    if (obs !== 29'd0) begin
      failures++;
      $display("[TB] FAIL reset_zero got=%h want=0", obs);
    end
    rst = 0;
    tick();
    checks++;
    if (sweep_start !== 1'b1 || gate_open !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_first_edge got start=%b gate=%b want 1 1", sweep_start, gate_open);
    end
    tx_pulse = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec) begin
        failures++;
        $display("[TB] FAIL reset_model cyc=%0d got=%h want=%h", cyc, obs, exp_vec);
      end
    end
  endtask

  // Blank 3, bin 2, four bins: fixed timeline relative to the edge cycle
  task automatic test_basic();
    longint t0, first_start, first_gate, last_gate, done_at;
    int strobes;
    logic [15:0] idx_seen [4];
    set_cfg(3, 2, 4);
    tx_pulse = 1;
    t0 = cyc; first_start = -1; first_gate = -1; last_gate = -1; done_at = -1; strobes = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      tx_pulse = 0;
      checks++;
      if (obs !== exp_vec) begin
        failures++;
        $display("[TB] FAIL basic_model cyc=%0d got=%h want=%h", cyc, obs, exp_vec);
      end
      if (sweep_start && first_start < 0) first_start = cyc - t0;
      if (gate_open && first_gate < 0) first_gate = cyc - t0;
      if (gate_open) last_gate = cyc - t0;
      if (sweep_done) done_at = cyc - t0;
      if (bin_strobe) begin
        if (strobes < 4) idx_seen[strobes] = bin_index;
        strobes++;
      end
    end
    checks++;
    if (first_start != 1 || first_gate != 4 || last_gate != 11 || done_at != 12) begin
      failures++;
      $display("[TB] FAIL basic_timeline got start=%0d gate=%0d..%0d done=%0d want 1 4..11 12",
               first_start, first_gate, last_gate, done_at);
    end
    checks++;
    if (strobes != 4 || idx_seen[0] !== 16'd0 || idx_seen[3] !== 16'd3) begin
      failures++;
      $display("[TB] FAIL basic_strobes got n=%0d first=%0d last=%0d want 4 0 3",
               strobes, idx_seen[0], idx_seen[3]);
    end
  endtask

  // Zero blanking with bin length 0 treated as 1
  task automatic test_zero_blank();
    set_cfg(0, 0, 1);
    tx_pulse = 1;
    tick();
    tx_pulse = 0;
    checks++;
    if ({sweep_start, gate_open, bin_strobe, busy} !== 4'b1111 || obs !== exp_vec) begin
      failures++;
      $display("[TB] FAIL zero_blank_first got=%h want start/gate/strobe/busy high", obs);
    end
    tick();
    checks++;
    if (sweep_done !== 1'b1 || gate_open !== 1'b0 || obs !== exp_vec) begin
      failures++;
      $display("[TB] FAIL zero_blank_done got done=%b gate=%b want 1 0", sweep_done, gate_open);
    end
    tick();
  endtask

  // Repeated edges during a long gate count up and saturate; clear wins
  task automatic test_overrun();
    int dones;
    dones = 0;
    set_cfg(0, 400, 2);
    tx_pulse = 1;
    tick();
    for (int i = 0; i < 300; i++) begin
      tx_pulse = 0;
      tick();
      checks++;
      if (obs !== exp_vec) begin
        failures++;
        $display("[TB] FAIL overrun_model cyc=%0d got=%h want=%h", cyc, obs, exp_vec);
      end
      tx_pulse = 1;
      tick();
      checks++;
      if (obs !== exp_vec) begin
        failures++;
        $display("[TB] FAIL overrun_model cyc=%0d got=%h want=%h", cyc, obs, exp_vec);
      end
      if (i == 0) begin
        checks++;
        if (overrun_cnt !== 8'd1) begin
          failures++;
          $display("[TB] FAIL overrun_first got=%0d want=1", overrun_cnt);
        end
      end
    end
    checks++;
    if (overrun_cnt !== 8'd255 || gate_open !== 1'b1) begin
      failures++;
      $display("[TB] FAIL overrun_saturate got cnt=%0d gate=%b want 255 1", overrun_cnt, gate_open);
    end
    tx_pulse = 0;
    tick();
    tx_pulse = 1;
    overrun_clr = 1;
    tick();
    overrun_clr = 0;
    tx_pulse = 0;
    checks++;
    if (overrun_cnt !== 8'd0) begin
      failures++;
      $display("[TB] FAIL overrun_clear got=%0d want=0", overrun_cnt);
    end
    for (int i = 0; i < 220; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec) begin
        failures++;
        $display("[TB] FAIL overrun_model cyc=%0d got=%h want=%h", cyc, obs, exp_vec);
      end
      if (sweep_done) dones++;
    end
    checks++;
    if (dones != 1) begin
      failures++;
      $display("[TB] FAIL overrun_sweep_done got=%0d want=1", dones);
    end
  endtask

  // A level held high produces exactly one sweep
  task automatic test_held_high();
    int starts;
    starts = 0;
    set_cfg(1, 1, 2);
    tx_pulse = 1;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec) begin
        failures++;
        $display("[TB] FAIL held_model cyc=%0d got=%h want=%h", cyc, obs, exp_vec);
      end
      if (sweep_start) starts++;
    end
    tx_pulse = 0;
    tick();
    checks++;
    if (starts != 1) begin
      failures++;
      $display("[TB] FAIL held_sweeps got=%0d want=1", starts);
    end
  endtask

  // An edge in the sweep_done cycle starts the next sweep without a gap
  task automatic test_back_to_back();
    set_cfg(1, 1, 2);
    tx_pulse = 1;
    tick();
    tx_pulse = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec) begin
        failures++;
        $display("[TB] FAIL b2b_model cyc=%0d got=%h want=%h", cyc, obs, exp_vec);
      end
    end
    checks++;
    if (sweep_done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_done got=%b want=1", sweep_done);
    end
    tx_pulse = 1;
    tick();
    tx_pulse = 0;
    checks++;
    if (sweep_start !== 1'b1 || busy !== 1'b1 || overrun_cnt !== 8'd0) begin
      failures++;
      $display("[TB] FAIL b2b_restart got start=%b busy=%b ovr=%0d want 1 1 0",
               sweep_start, busy, overrun_cnt);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec) begin
        failures++;
        $display("[TB] FAIL b2b_model cyc=%0d got=%h want=%h", cyc, obs, exp_vec);
      end
    end
  endtask

  // Dropping enable inside bin 2 aborts silently
  task automatic test_enable_abort();
    bit found;
    int dones;
    found = 0;
    dones = 0;
    set_cfg(1, 2, 4);
    tx_pulse = 1;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      tx_pulse = 0;
      checks++;
      if (obs !== exp_vec) begin
        failures++;
        $display("[TB] FAIL abort_model cyc=%0d got=%h want=%h", cyc, obs, exp_vec);
      end
      if (gate_open && bin_index == 16'd2) found = 1;
    end
    if (!found) begin
      checks++;
      failures++;
      $display("[TB] FAIL abort_wait got no bin 2 within 40 cycles want bin 2");
    end
    enable = 0;
    tick();
    enable = 1;
    checks++;
    if (gate_open !== 1'b0 || bin_index !== 16'd0 || busy !== 1'b0 || sweep_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_next got gate=%b idx=%0d busy=%b done=%b want 0 0 0 0",
               gate_open, bin_index, busy, sweep_done);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (sweep_done) dones++;
    end
    checks++;
    if (dones != 0 || obs !== exp_vec) begin
      failures++;
      $display("[TB] FAIL abort_no_done got dones=%0d obs=%h want 0 %h", dones, obs, exp_vec);
    end
  endtask

  // Reset in the blanking interval clears all outputs next cycle
  task automatic test_reset_mid_blank();
    set_cfg(10, 2, 2);
    tx_pulse = 1;
    tick();
    tx_pulse = 0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b1 || gate_open !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_blank_pre got busy=%b gate=%b want 1 0", busy, gate_open);
    end
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (obs !== 29'd0) begin
      failures++;
      $display("[TB] FAIL rst_blank_zero got=%h want=0", obs);
    end
    tick();
  endtask

  // A trigger with zero bins does nothing at all
  task automatic test_zero_bins();
    int seen;
    seen = 0;
    set_cfg(0, 1, 0);
    tx_pulse = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      tx_pulse = 0;
      if (sweep_start || busy || gate_open) seen++;
    end
    checks++;
    if (seen != 0 || overrun_cnt !== 8'd0) begin
      failures++;
      $display("[TB] FAIL zero_bins got active_cycles=%0d ovr=%0d want 0 0", seen, overrun_cnt);
    end
  endtask

  // Random inputs, including mid-sweep config changes, against the model
  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 399) == 0);
      enable       = ($urandom_range(0, 99) != 0);
      overrun_clr  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 5) == 0) tx_pulse = ~tx_pulse;
      blank_cycles = CFG_W'($urandom_range(0, 4));
      bin_cycles   = CFG_W'($urandom_range(0, 3));
      num_bins     = BIN_W'($urandom_range(0, 4));
      tick();
      checks++;
      if (obs !== exp_vec) begin
        failures++;
        $display("[TB] FAIL random_model cyc=%0d got=%h want=%h", cyc, obs, exp_vec);
      end
    end
    rst = 0; enable = 1; overrun_clr = 0; tx_pulse = 0;
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    m_tx_d = 0; m_active = 0; m_s = 0; m_blank = 0; m_bl = 1; m_nb = 0; m_ovr = 0;
    rst = 1; enable = 0; tx_pulse = 0; overrun_clr = 0;
    blank_cycles = '0; bin_cycles = '0; num_bins = '0;
    test_reset();
    test_basic();
    test_zero_blank();
    test_overrun();
    test_held_high();
    test_back_to_back();
    test_enable_abort();
    test_reset_mid_blank();
    test_zero_bins();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
